// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives requests and operands; the slave returns status and result.
interface serial_add_ctrl_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell, operands consumed LSB-first,
// carry held in a flop between bits. Result appears N cycles after acceptance
// and is held on S/Cout until the next operation completes.
module serial_add_ctrl #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_ra, w_ra_nxt;
    logic [N-1:0]   r_rb, w_rb_nxt;
    logic [N-1:0]   r_rs, w_rs_nxt;
    logic           r_cy, w_cy_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [N-1:0]   r_s, w_s_nxt;
    logic           r_cout, w_cout_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;

    logic           w_fa_p;
    logic           w_fa_s;
    logic           w_fa_c;
    logic [N-1:0]   w_rs_shift;

    // Shared full-adder cell on the current LSBs and the stored carry
    assign w_fa_p = r_ra[0] ^ r_rb[0];
    assign w_fa_s = w_fa_p ^ r_cy;
    assign w_fa_c = (r_ra[0] & r_rb[0]) | (w_fa_p & r_cy);

    // Sum bit enters at the MSB so after N shifts bit 0 sits at rs[0]
    assign w_rs_shift = (r_rs >> 1) | (N'(w_fa_s) << (N - 1));

    // Next-state, datapath and registered status decode
    always_comb begin
        w_state_nxt = r_state;
        w_ra_nxt    = r_ra;
        w_rb_nxt    = r_rb;
        w_rs_nxt    = r_rs;
        w_cy_nxt    = r_cy;
        w_cnt_nxt   = r_cnt;
        w_s_nxt     = r_s;
        w_cout_nxt  = r_cout;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_ra_nxt    = bus.A;
                    w_rb_nxt    = bus.B;
                    w_cy_nxt    = bus.Cin;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRun;
                    w_busy_nxt  = 1'b1;
                end
            end
            StRun: begin
                w_ra_nxt  = r_ra >> 1;
                w_rb_nxt  = r_rb >> 1;
                w_rs_nxt  = w_rs_shift;
                w_cy_nxt  = w_fa_c;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(N - 1)) begin
                    w_s_nxt     = w_rs_shift;
                    w_cout_nxt  = w_fa_c;
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rs    <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ra    <= w_ra_nxt;
            r_rb    <= w_rb_nxt;
            r_rs    <= w_rs_nxt;
            r_cy    <= w_cy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= w_s_nxt;
            r_cout  <= w_cout_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.S    = r_s;
    assign bus.Cout = r_cout;

endmodule
